// File: rtl/mac_pkg.sv
// Shared widths, result payload and requantization helper for the MAC psum collector.
//   BW/BW_PSUM/BW_ACC/BW_OUT : default datapath widths
//   res_t                    : {sat, q} result payload stored in the result FIFO
//   sat_round()              : round-half-up, arithmetic shift, saturate to bw_out
package mac_pkg;

    localparam int unsigned BW      = 8;
    localparam int unsigned BW_PSUM = 2 * BW + 4;
    localparam int unsigned BW_ACC  = BW_PSUM + 8;
    localparam int unsigned BW_OUT  = 8;
    // Working width: accumulator plus headroom so the rounding add never wraps.
    localparam int unsigned SR_W    = BW_ACC + 32;

    typedef struct packed {
        logic                     sat;
        logic signed [BW_OUT-1:0] q;
    } res_t;

    // Rounds half toward +inf, shifts right arithmetically, clips to a signed bw_out range.
    function automatic res_t sat_round(input logic signed [SR_W-1:0] v,
                                       input logic        [4:0]      shift,
                                       input int unsigned            bw_out);
        logic signed [SR_W-1:0] rnd;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        res_t                   r;
        r   = '0;
        hi  = signed'((SR_W'(1) << (bw_out - 1)) - SR_W'(1));
        lo  = -hi - signed'(SR_W'(1));
        if (shift == 5'd0) begin
            rnd = v;
        end else begin
            rnd = (v + signed'(SR_W'(1) << (shift - 5'd1))) >>> shift;
        end
        if (rnd > hi) begin
            r.sat = 1'b1;
            r.q   = BW_OUT'(hi);
        end else if (rnd < lo) begin
            r.sat = 1'b1;
            r.q   = BW_OUT'(lo);
        end else begin
            r.q   = BW_OUT'(rnd);
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_result_fifo.sv
// Synchronous result FIFO; head entry is presented directly from the storage registers.
//   clk, rst          : clock, synchronous active-high reset
//   i_push, i_wdata   : write request and data (ignored when full unless popping)
//   i_pop             : remove head (ignored when empty)
//   o_rdata           : head entry
//   o_count           : number of stored entries
//   o_full, o_empty   : occupancy flags
module psum_result_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // At full, a concurrent pop frees the slot the write pointer is aimed at.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, power-of-two pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mac_psum_collector.sv
// Collects MAC partial sums, accumulates one dot product, requantizes and queues results.
//   clk, rst                      : clock, synchronous active-high reset
//   psum_in, in_valid, in_last    : MAC chunk stream (in_last marks final chunk)
//   cfg_shift                     : requant right shift, static while results are pending
//   issue_ready                   : credit to issue a last chunk into the MAC this cycle
//   out_data, out_sat, out_valid  : head result, its saturation flag, FIFO non-empty
//   out_ready                     : consumer accepts the head
//   overflow_err                  : sticky, a result was dropped on a full FIFO
module mac_psum_collector
    import mac_pkg::*;
#(
    parameter int unsigned bw      = BW,
    parameter int unsigned bw_psum = 2 * bw + 4,
    parameter int unsigned bw_acc  = bw_psum + 8,
    parameter int unsigned bw_out  = BW_OUT,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [bw_psum-1:0] psum_in,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic        [4:0]         cfg_shift,
    output logic                      issue_ready,
    output logic signed [bw_out-1:0]  out_data,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RES_W = $bits(res_t);

    logic signed [bw_acc-1:0] r_acc;
    logic                     r_first;
    logic signed [bw_acc-1:0] r_val_a;
    logic                     r_valid_a;
    logic                     r_issue_ready;
    logic                     r_overflow;

    logic signed [bw_acc-1:0] w_psum_ext;
    logic signed [bw_acc-1:0] w_acc_next;
    res_t                     w_res;
    res_t                     w_head;
    logic [RES_W-1:0]         w_head_bits;
    logic                     w_push;
    logic                     w_push_ok;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_full;
    logic                     w_empty;
    logic [CNT_W-1:0]         w_count;
    logic [CNT_W-1:0]         w_count_next;
    logic                     w_issue_next;

    assign w_psum_ext = bw_acc'(psum_in);
    assign w_acc_next = r_first ? w_psum_ext : r_acc + w_psum_ext;

    // Stage B: requantize the stage A value and push it in the same cycle.
    assign w_res     = sat_round(SR_W'(r_val_a), cfg_shift, bw_out);
    assign w_push    = r_valid_a;
    assign w_pop     = out_ready & ~w_empty;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & ~w_push_ok;

    // Credit is precomputed from next-cycle occupancy so issue_ready can be a flop.
    // Slack of 3 covers the two MAC stages plus the issue cycle itself.
    assign w_count_next = w_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    assign w_issue_next = ({1'b0, w_count_next} + (CNT_W + 1)'(in_valid & in_last))
                          <= (CNT_W + 1)'(DEPTH - 3);

    // Accumulator, stage A and status flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_first       <= 1'b1;
            r_val_a       <= '0;
            r_valid_a     <= 1'b0;
            r_issue_ready <= 1'b1;
            r_overflow    <= 1'b0;
        end else begin
            if (in_valid) begin
                r_acc   <= w_acc_next;
                r_first <= in_last;
            end
            r_valid_a     <= in_valid & in_last;
            r_val_a       <= w_acc_next;
            r_issue_ready <= w_issue_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    psum_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_res),
        .i_pop   (w_pop),
        .o_rdata (w_head_bits),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head       = res_t'(w_head_bits);
    assign out_data     = w_head.q;
    assign out_sat      = w_head.sat;
    assign out_valid    = ~w_empty;
    assign issue_ready  = r_issue_ready;
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_mac_psum_collector.sv
module tb_mac_psum_collector;

    logic               clk;
    logic               rst;
    logic signed [19:0] psum_in;
    logic               in_valid;
    logic               in_last;
    logic        [4:0]  cfg_shift;
    logic               out_ready;
    logic               issue_ready;
    logic signed [7:0]  out_data;
    logic               out_sat;
    logic               out_valid;
    logic               overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    mac_psum_collector dut (
        .clk          (clk),
        .rst          (rst),
        .psum_in      (psum_in),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .cfg_shift    (cfg_shift),
        .issue_ready  (issue_ready),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one chunk for a single cycle.
    task automatic send(input int v, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        psum_in  = 20'(v);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        psum_in  = '0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic       pipe_v [2];
    int         pipe_d [2];
    int         issued;
    logic       ir;

    initial begin
        rst       = 1'b1;
        psum_in   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        cfg_shift = 5'd0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_issue_ready", int'(issue_ready), 1);
        check("rst_overflow", int'(overflow_err), 0);
        rst = 1'b0;
        step();

        // 1: single chunk, shift 0, latency t+2
        send(100, 1'b1);
        check("t1_valid_t1", int'(out_valid), 0);
        step();
        check("t1_valid_t2", int'(out_valid), 1);
        check("t1_data", int'(out_data), 100);
        check("t1_sat", int'(out_sat), 0);
        step();
        check("t1_hold_data", int'(out_data), 100);
        pop_one();
        check("t1_empty", int'(out_valid), 0);

        // 2: three-chunk dot product with rounding, then negative rounding
        cfg_shift = 5'd4;
        send(1000, 1'b0);
        send(-200, 1'b0);
        send(300, 1'b1);
        check("t2_valid_t1", int'(out_valid), 0);
        step();
        check("t2_data", int'(out_data), 69);
        check("t2_sat", int'(out_sat), 0);
        pop_one();
        send(-24, 1'b1);
        step();
        check("t2_neg_data", int'(out_data), -1);
        pop_one();

        // 3: saturation both ways, back to back
        cfg_shift = 5'd0;
        send(5000, 1'b1);
        send(-5000, 1'b1);
        check("t3_pos_data", int'(out_data), 127);
        check("t3_pos_sat", int'(out_sat), 1);
        pop_one();
        check("t3_neg_data", int'(out_data), -128);
        check("t3_neg_sat", int'(out_sat), 1);
        pop_one();
        check("t3_empty", int'(out_valid), 0);

        // 4: credit-obeying issuer with a 2-cycle MAC delay, consumer stalled
        pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
        pipe_d[0] = 0;    pipe_d[1] = 0;
        issued    = 0;
        for (int c = 0; c < 14; c++) begin
            ir = issue_ready;
            if (c == 7) check("t4_ready_c7", int'(ir), 1);
            if (c == 8) check("t4_ready_c8", int'(ir), 0);
            in_valid  = pipe_v[1];
            in_last   = 1'b1;
            psum_in   = 20'(pipe_d[1]);
            pipe_v[1] = pipe_v[0];
            pipe_d[1] = pipe_d[0];
            pipe_v[0] = ir;
            pipe_d[0] = 3 * issued + 1;
            if (ir) issued++;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        check("t4_issued", issued, 8);
        check("t4_overflow", int'(overflow_err), 0);
        check("t4_ready_full", int'(issue_ready), 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t4_data%0d", k), int'(out_data), 3 * k + 1);
            pop_one();
        end
        check("t4_empty", int'(out_valid), 0);

        // 5: ignore credit, ninth result dropped, first eight intact
        for (int k = 0; k < 9; k++) send(11 + k, 1'b1);
        check("t5_ovf_before", int'(overflow_err), 0);
        step();
        check("t5_ovf_set", int'(overflow_err), 1);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5_data%0d", k), int'(out_data), 11 + k);
            pop_one();
        end
        check("t5_empty", int'(out_valid), 0);
        check("t5_ovf_sticky", int'(overflow_err), 1);
        do_reset();
        check("t5_ovf_cleared", int'(overflow_err), 0);

        // 6: reset mid-accumulation with a pending result
        send(33, 1'b1);
        send(50, 1'b0);
        check("t6_pending", int'(out_valid), 1);
        send(60, 1'b0);
        rst = 1'b1;
        step();
        check("t6_valid_in_rst", int'(out_valid), 0);
        check("t6_data_in_rst", int'(out_data), 0);
        step();
        rst = 1'b0;
        step();
        check("t6_valid_after", int'(out_valid), 0);
        send(7, 1'b1);
        step();
        check("t6_data", int'(out_data), 7);
        check("t6_sat", int'(out_sat), 0);
        pop_one();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
